// File: rtl/pipe_wrap_pkg.sv
// Shared types and constants for the pipeline frame wrapper.
// Holds the frame state encoding and the MMIO word width.
package pipe_wrap_pkg;

    localparam int MMIO_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int default_rst_cycles();
        return 32'sd4;
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry valid/ready register slice with a registered upstream ready.
// A synchronous clear empties the slice and drops its contents.
module skid_buf2 #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic [1:0]        cnt_r;
    logic [1:0]        cnt_s;
    logic [DATA_W-1:0] head_r;
    logic [DATA_W-1:0] tail_r;
    logic              ready_r;
    logic              push_s;
    logic              pop_s;

    assign push_s    = in_valid & ready_r;
    assign pop_s     = (cnt_r != 2'd0) & out_ready;
    assign in_ready  = ready_r;
    assign out_valid = (cnt_r != 2'd0);
    assign out_data  = head_r;

    // Next occupancy from push/pop, with clear taking priority
    always_comb begin
        cnt_s = cnt_r;
        if (clear) begin
            cnt_s = 2'd0;
        end else if (push_s && !pop_s) begin
            cnt_s = cnt_r + 2'd1;
        end else if (pop_s && !push_s) begin
            cnt_s = cnt_r - 2'd1;
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Occupancy and upstream ready; ready reflects room in the coming cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= 2'd0;
            ready_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_s;
            ready_r <= enable & (cnt_s != 2'd2);
        end
    end

    // Entry storage: head is always the oldest entry
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r <= {DATA_W{1'b0}};
            tail_r <= {DATA_W{1'b0}};
        end else if (pop_s) begin
            if (push_s && (cnt_r == 2'd1)) begin
                head_r <= in_data;
            end else begin
                head_r <= tail_r;
            end
            if (push_s && (cnt_r == 2'd2)) begin
                tail_r <= in_data;
            end else begin
                tail_r <= tail_r;
            end
        end else if (push_s) begin
            if (cnt_r == 2'd0) begin
                head_r <= in_data;
            end else begin
                tail_r <= in_data;
            end
        end else begin
            head_r <= head_r;
            tail_r <= tail_r;
        end
    end

endmodule

// File: rtl/pipe_frame_wrap.sv
// Frames one run of an attached streaming pipeline: snapshot config on start,
// hold the pipeline in reset, then stream until the output count is reached.
module pipe_frame_wrap
    import pipe_wrap_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int N_MMIO     = 4,
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = default_rst_cycles()
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [CNT_W-1:0]         in_tokens,
    input  logic [CNT_W-1:0]         out_tokens,
    input  logic [N_MMIO*MMIO_W-1:0] mmio,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     pipe_reset,
    output logic [N_MMIO*MMIO_W-1:0] pipe_mmio,
    output logic                     pipe_in_valid,
    input  logic                     pipe_in_ready,
    output logic [DATA_W-1:0]        pipe_in_data,
    input  logic                     pipe_out_valid,
    output logic                     pipe_out_ready,
    input  logic [DATA_W-1:0]        pipe_out_data,
    output logic                     busy,
    output logic                     done
);

    localparam int FL_W = (RST_CYCLES > 32'sd1) ? $clog2(RST_CYCLES) : 32'sd1;
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(RST_CYCLES - 32'sd1);

    state_e                     state_r;
    state_e                     state_s;
    logic [CNT_W-1:0]           in_cnt_r;
    logic [CNT_W-1:0]           out_cnt_r;
    logic [CNT_W-1:0]           in_tokens_r;
    logic [CNT_W-1:0]           out_tokens_r;
    logic [N_MMIO*MMIO_W-1:0]   mmio_r;
    logic [FL_W-1:0]            flush_cnt_r;
    logic                       run_s;
    logic                       in_open_s;
    logic                       in_beat_s;
    logic                       out_beat_s;
    logic                       last_out_s;
    logic                       buf_en_s;
    logic                       buf_clear_s;
    logic                       accept_start_s;

    assign run_s          = (state_r == RUN);
    assign accept_start_s = (state_r == IDLE) & start;
    assign in_open_s      = (in_cnt_r != in_tokens_r);
    assign in_ready       = run_s & pipe_in_ready & in_open_s;
    assign pipe_in_valid  = run_s & in_valid & in_open_s;
    assign pipe_in_data   = in_data;
    assign in_beat_s      = in_valid & in_ready;
    assign out_beat_s     = out_valid & out_ready;
    assign last_out_s     = out_beat_s & ((out_cnt_r + CNT_W'(1)) == out_tokens_r);

    // The skid only accepts while running; leaving RUN drops anything still held
    assign buf_en_s    = (state_s == RUN);
    assign buf_clear_s = (state_s != RUN);

    assign pipe_reset = (state_r != RUN);
    assign pipe_mmio  = mmio_r;
    assign busy       = (state_r == FLUSH) | (state_r == RUN);
    assign done       = (state_r == DONE);

    // Frame state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame sequencing; a zero output count skips RUN entirely
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = FLUSH;
                end else begin
                    state_s = IDLE;
                end
            end
            FLUSH: begin
                if (flush_cnt_r != FL_LAST) begin
                    state_s = FLUSH;
                end else if (out_tokens_r == {CNT_W{1'b0}}) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            RUN: begin
                if (last_out_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Config snapshot, flush timer and beat counters
    always_ff @(posedge clk) begin
        if (reset) begin
            in_tokens_r  <= {CNT_W{1'b0}};
            out_tokens_r <= {CNT_W{1'b0}};
            mmio_r       <= {(N_MMIO*MMIO_W){1'b0}};
            in_cnt_r     <= {CNT_W{1'b0}};
            out_cnt_r    <= {CNT_W{1'b0}};
            flush_cnt_r  <= {FL_W{1'b0}};
        end else if (accept_start_s) begin
            in_tokens_r  <= in_tokens;
            out_tokens_r <= out_tokens;
            mmio_r       <= mmio;
            in_cnt_r     <= {CNT_W{1'b0}};
            out_cnt_r    <= {CNT_W{1'b0}};
            flush_cnt_r  <= {FL_W{1'b0}};
        end else begin
            if (state_r == FLUSH) begin
                flush_cnt_r <= flush_cnt_r + FL_W'(1);
            end
            if (in_beat_s) begin
                in_cnt_r <= in_cnt_r + CNT_W'(1);
            end
            if (out_beat_s) begin
                out_cnt_r <= out_cnt_r + CNT_W'(1);
            end
        end
    end

    skid_buf2 #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .clear     (buf_clear_s),
        .enable    (buf_en_s),
        .in_valid  (pipe_out_valid),
        .in_ready  (pipe_out_ready),
        .in_data   (pipe_out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_pipe_frame_wrap.sv
// Self-checking bench for pipe_frame_wrap with an identity pipeline and a
// scoreboard queue of expected output beats.
module tb_pipe_frame_wrap;

    localparam int DATA_W = 64;
    localparam int N_MMIO = 4;
    localparam int CNT_W  = 32;
    localparam int RST_CY = 4;

    logic                   clk;
    logic                   reset;
    logic                   start;
    logic [CNT_W-1:0]       in_tokens;
    logic [CNT_W-1:0]       out_tokens;
    logic [N_MMIO*32-1:0]   mmio;
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_data;
    logic                   pipe_reset;
    logic [N_MMIO*32-1:0]   pipe_mmio;
    logic                   pipe_in_valid;
    logic                   pipe_in_ready;
    logic [DATA_W-1:0]      pipe_in_data;
    logic                   pipe_out_valid;
    logic                   pipe_out_ready;
    logic [DATA_W-1:0]      pipe_out_data;
    logic                   busy;
    logic                   done;

    pipe_frame_wrap dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .in_tokens      (in_tokens),
        .out_tokens     (out_tokens),
        .mmio           (mmio),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .pipe_reset     (pipe_reset),
        .pipe_mmio      (pipe_mmio),
        .pipe_in_valid  (pipe_in_valid),
        .pipe_in_ready  (pipe_in_ready),
        .pipe_in_data   (pipe_in_data),
        .pipe_out_valid (pipe_out_valid),
        .pipe_out_ready (pipe_out_ready),
        .pipe_out_data  (pipe_out_data),
        .busy           (busy),
        .done           (done)
    );

    // Zero-latency identity pipeline
    assign pipe_out_valid = pipe_in_valid;
    assign pipe_out_data  = pipe_in_data;
    assign pipe_in_ready  = pipe_out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           in_tok;
        int           out_tok;
        logic [127:0] mmio;
        int           valid_cyc;
        int           pat;
        int           spur;
        int           abort_at;
        int           exp_in;
        int           exp_out;
        int           exp_flush;
    } vec_t;

    vec_t         vecs [8];
    int           n_checks = 0;
    int           n_fail = 0;
    logic [63:0]  exp_q [$];
    int           occ = 0;
    int           in_acc, out_seen, done_cnt, in_rdy_cyc, out_vld_cyc;
    int           cur_in_tok = 0;
    logic [127:0] cur_mmio = 128'd0;
    int           frame_id = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample #1 after the falling edge, update scoreboard, advance
    task automatic cycle();
        logic        pob;
        logic        ob;
        logic [63:0] e;
        #1;
        if (in_ready)  in_rdy_cyc++;
        if (out_valid) out_vld_cyc++;
        if (done)      done_cnt++;
        if (busy) chk("pipe_mmio_stable", pipe_mmio, cur_mmio);
        if (busy && !pipe_reset && in_acc >= cur_in_tok) chk("in_closed", 128'(in_ready), 128'd0);
        if (!pipe_reset) begin
            chk("pipe_out_ready_vs_occ", 128'(pipe_out_ready), 128'(occ < 2));
            chk("out_valid_vs_occ", 128'(out_valid), 128'(occ != 0));
        end else begin
            occ = 0;
        end
        pob = pipe_out_valid & pipe_out_ready;
        ob  = out_valid & out_ready;
        occ = occ + int'(pob) - int'(ob);
        if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
            in_acc++;
        end
        if (ob) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_extra: got beat %0h, expected no beat", out_data);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 128'(out_data), 128'(e));
            end
            out_seen++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_frame(input vec_t v);
        int run_cyc;
        int flush_cyc;
        bit seen_done;
        bit aborted;
        in_acc = 0; out_seen = 0; done_cnt = 0; in_rdy_cyc = 0; out_vld_cyc = 0;
        run_cyc = 0; flush_cyc = 0; seen_done = 1'b0; aborted = 1'b0;
        frame_id++;
        cur_in_tok = v.in_tok;
        cur_mmio   = v.mmio;
        in_tokens  = 32'(v.in_tok);
        out_tokens = 32'(v.out_tok);
        mmio       = v.mmio;
        start      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        cycle();
        start      = 1'b0;
        in_tokens  = 32'd3;
        out_tokens = 32'd3;
        mmio       = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 400 && !seen_done && !aborted; c++) begin
            if (done) begin
                seen_done = 1'b1;
            end else begin
                in_valid = 1'b0;
                if (busy && pipe_reset) flush_cyc++;
                if (busy && !pipe_reset) begin
                    in_valid  = (v.valid_cyc == 0) || (run_cyc < v.valid_cyc);
                    in_data   = {frame_id, in_acc};
                    out_ready = (v.pat == 0) || (run_cyc % 4 == 0) || (run_cyc % 4 == 3);
                    start     = (v.spur != 0) && (run_cyc == 2);
                    reset     = (v.abort_at != 0) && (in_acc == v.abort_at);
                    run_cyc++;
                end
                cycle();
                start = 1'b0;
                if (reset) begin
                    reset   = 1'b0;
                    aborted = 1'b1;
                end
            end
        end
        if (aborted) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            #1;
            chk("abort_in_ready", 128'(in_ready), 128'd0);
            chk("abort_pipe_in_valid", 128'(pipe_in_valid), 128'd0);
            chk("abort_out_valid", 128'(out_valid), 128'd0);
            chk("abort_busy", 128'(busy), 128'd0);
            chk("abort_done", 128'(done), 128'd0);
            chk("abort_pipe_reset", 128'(pipe_reset), 128'd1);
            chk("abort_pipe_mmio", pipe_mmio, 128'd0);
            chk("abort_pipe_out_ready", 128'(pipe_out_ready), 128'd0);
            exp_q.delete();
            occ      = 0;
            in_valid = 1'b0;
            done_cnt = 0;
            for (int i = 0; i < 10; i++) cycle();
            chk("no_done_after_abort", 128'(done_cnt), 128'd0);
        end else if (seen_done) begin
            chk("done_pipe_reset", 128'(pipe_reset), 128'd1);
            chk("done_out_valid", 128'(out_valid), 128'd0);
            chk("done_pipe_mmio", pipe_mmio, v.mmio);
            start    = (v.spur != 0);
            in_valid = 1'b1;
            cycle();
            start    = 1'b0;
            in_valid = 1'b0;
            chk("post_done_busy", 128'(busy), 128'd0);
            chk("post_done_done", 128'(done), 128'd0);
            chk("post_done_pipe_reset", 128'(pipe_reset), 128'd1);
            chk("done_pulses", 128'(done_cnt), 128'd1);
            chk("in_beats", 128'(in_acc), 128'(v.exp_in));
            chk("out_beats", 128'(out_seen), 128'(v.exp_out));
            chk("flush_cycles", 128'(flush_cyc), 128'(v.exp_flush));
            chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
            if (v.out_tok == 0) begin
                chk("zero_run_cycles", 128'(run_cyc), 128'd0);
                chk("zero_in_ready_cycles", 128'(in_rdy_cyc), 128'd0);
                chk("zero_out_valid_cycles", 128'(out_vld_cyc), 128'd0);
            end
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout: got no done, expected done within 400 cycles");
        end
    endtask

    initial begin
        //              in  out mmio                                     vcy pat spr abt ein eout efl
        vecs[0] = '{8,  8,  128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978, 0,  0, 0, 0, 8,  8,  RST_CY};
        vecs[1] = '{5,  5,  128'h1111_2222_3333_4444_5555_6666_7777_8888, 10, 0, 0, 0, 5,  5,  RST_CY};
        vecs[2] = '{16, 16, 128'hdead_beef_cafe_f00d_1234_5678_9abc_def0, 0,  1, 0, 0, 16, 16, RST_CY};
        vecs[3] = '{0,  0,  128'ha5a5_a5a5_5a5a_5a5a_ffff_0000_ffff_0000, 0,  0, 0, 0, 0,  0,  RST_CY};
        vecs[4] = '{8,  8,  128'h0bad_0bad_0bad_0bad_0bad_0bad_0bad_0bad, 0,  0, 0, 3, 0,  0,  RST_CY};
        vecs[5] = '{8,  8,  128'h7777_6666_5555_4444_3333_2222_1111_0000, 0,  0, 0, 0, 8,  8,  RST_CY};
        vecs[6] = '{8,  8,  128'hfeed_face_0000_0001_0000_0002_0000_0003, 0,  0, 1, 0, 8,  8,  RST_CY};
        vecs[7] = '{3,  3,  128'h0000_0000_0000_0000_0000_0000_0000_0042, 0,  1, 0, 0, 3,  3,  RST_CY};

        reset      = 1'b1;
        start      = 1'b0;
        in_tokens  = 32'd0;
        out_tokens = 32'd0;
        mmio       = 128'd0;
        in_valid   = 1'b1;
        in_data    = 64'd0;
        out_ready  = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_pipe_in_valid", 128'(pipe_in_valid), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_pipe_reset", 128'(pipe_reset), 128'd1);
        chk("rst_pipe_mmio", pipe_mmio, 128'd0);
        chk("rst_pipe_out_ready", 128'(pipe_out_ready), 128'd0);
        reset = 1'b0;
        cycle();
        cycle();
        chk("idle_in_ready", 128'(in_ready), 128'd0);
        chk("idle_pipe_reset", 128'(pipe_reset), 128'd1);
        in_valid = 1'b0;

        for (int k = 0; k < 8; k++) begin
            run_frame(vecs[k]);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
